// File: rtl/stim_capture_harness.sv
// ---------------------------------------------------------------------------
// stim_capture_harness
//
// Purpose: stimulus/capture harness for the control-bounded filter. The host
// loads N-bit control samples into a stimulus RAM and starts a run. The
// harness then holds the DUT in reset, streams one sample per clk into the
// DUT and captures every OSR-th DUT result into a result RAM. The host reads
// that RAM back after done.
//
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   ld_clr           pulse: empty the stimulus RAM (pointer/count to 0)
//   ld_valid/ready   stimulus load handshake, ld_data is the word
//   start            pulse: begin a run (IDLE only, effective length > 0)
//   length/skip/loop run length, decimated results to discard, wrap enable
//   dut_rst_n/dut_in DUT reset (active low) and sample stream
//   dut_out          DUT result, sampled at the edge ending a capture cycle
//   rd_addr/rd_data  result readback, one cycle read latency
//   cap_count        results written by the last run
//   busy/done        run in progress / one-cycle end-of-run pulse
//   overflow         sticky: more results than DEPTH_OUT in this run
//   dbg_state        current FSM state for debug
//
// Load handshake: a word is transferred on every clk edge where
// ld_valid && ld_ready are both high. ld_valid may be held while ld_ready is
// low; nothing is transferred and nothing changes. ld_ready does not depend
// on ld_valid.
// ---------------------------------------------------------------------------
module stim_capture_harness #(
    parameter int N         = 3,
    parameter int DEPTH_IN  = 4096,
    parameter int DEPTH_OUT = 4096,
    parameter int OSR       = 1,
    parameter int FLOAT_W   = 32,
    parameter int RST_CYC   = 5,
    parameter int DRAIN_CYC = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ld_clr,
    input  logic                           ld_valid,
    input  logic [N-1:0]                   ld_data,
    output logic                           ld_ready,
    input  logic                           start,
    input  logic [$clog2(DEPTH_IN+1)-1:0]  length,
    input  logic [15:0]                    skip,
    input  logic                           loop,
    output logic                           dut_rst_n,
    output logic [N-1:0]                   dut_in,
    input  logic [FLOAT_W-1:0]             dut_out,
    input  logic [$clog2(DEPTH_OUT)-1:0]   rd_addr,
    output logic [FLOAT_W-1:0]             rd_data,
    output logic [$clog2(DEPTH_OUT+1)-1:0] cap_count,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow,
    output logic [2:0]                     dbg_state
);

    localparam int LW     = $clog2(DEPTH_IN + 1);
    localparam int AW_IN  = (DEPTH_IN > 1) ? $clog2(DEPTH_IN) : 1;
    localparam int AW_OUT = $clog2(DEPTH_OUT);
    localparam int CAPW   = $clog2(DEPTH_OUT + 1);
    localparam int DW     = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int CW_A   = (LW > $clog2(RST_CYC + 1)) ? LW : $clog2(RST_CYC + 1);
    localparam int CW     = (CW_A > $clog2(DRAIN_CYC + 1)) ? CW_A : $clog2(DRAIN_CYC + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RESET = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [LW-1:0]      r_loaded;
    logic [LW-1:0]      r_len;
    logic [LW-1:0]      w_eff_len;
    logic               r_loop;
    logic [AW_IN-1:0]   r_rd_ptr;
    logic [AW_IN-1:0]   w_rd_ptr_nxt;
    logic [AW_IN-1:0]   w_last_ptr;
    logic [CW-1:0]      r_cnt;
    logic               w_cnt_end;
    logic [DW-1:0]      r_dec;
    logic               w_dec_hit;
    logic [15:0]        r_skip_cnt;
    logic [CAPW-1:0]    r_cap_count;
    logic               r_overflow;
    logic               r_busy;
    logic               r_done;
    logic               r_dut_rst_n;
    logic [N-1:0]       r_dut_in;
    logic [FLOAT_W-1:0] r_rd_data;
    logic               w_ld_we;
    logic               w_start_ok;
    logic               w_capturing;
    logic               w_res_we;

    logic [N-1:0]       r_stim_ram [DEPTH_IN];
    logic [FLOAT_W-1:0] r_res_ram  [DEPTH_OUT];

    // ld_ready is gated by rst so it reads 0 while reset is held.
    assign ld_ready   = rst && (r_state == S_IDLE) && (r_loaded != LW'(DEPTH_IN));
    assign w_ld_we    = ld_valid && ld_ready && !ld_clr;

    // With loop=1 the stored block repeats, so any length works once loaded.
    always_comb begin
        w_eff_len = '0;
        if (loop) begin
            if (r_loaded != '0) w_eff_len = length;
        end else begin
            w_eff_len = (length < r_loaded) ? length : r_loaded;
        end
    end

    assign w_start_ok = (r_state == S_IDLE) && start && (w_eff_len != '0);

    always_comb begin
        w_cnt_end = 1'b0;
        case (r_state)
            S_RESET: w_cnt_end = (r_cnt == CW'(RST_CYC - 1));
            S_RUN:   w_cnt_end = (r_cnt == (CW'(r_len) - CW'(1)));
            S_DRAIN: w_cnt_end = (r_cnt == CW'(DRAIN_CYC - 1));
            default: w_cnt_end = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_RESET;
            S_RESET: if (w_cnt_end)  w_state_nxt = S_RUN;
            S_RUN:   if (w_cnt_end)  w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_cnt_end)  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Stimulus read pointer runs one sample ahead of dut_in; it wraps only
    // in loop mode, after the last loaded word.
    assign w_last_ptr   = AW_IN'(r_loaded - LW'(1));
    assign w_rd_ptr_nxt = (r_loop && (r_rd_ptr == w_last_ptr)) ? '0 : r_rd_ptr + AW_IN'(1);

    assign w_capturing  = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_dec_hit    = (r_dec == DW'(OSR - 1));
    assign w_res_we     = w_capturing && w_dec_hit && (r_skip_cnt == 16'd0) &&
                          (r_cap_count != CAPW'(DEPTH_OUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_loaded    <= '0;
            r_len       <= '0;
            r_loop      <= 1'b0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_dec       <= '0;
            r_skip_cnt  <= '0;
            r_cap_count <= '0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dut_rst_n <= 1'b0;
            r_dut_in    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            // Status outputs are decoded from the next state so they are
            // glitch-free registers aligned with r_state.
            r_busy      <= (w_state_nxt == S_RESET) || (w_state_nxt == S_RUN) ||
                           (w_state_nxt == S_DRAIN);
            r_done      <= (w_state_nxt == S_DONE);
            r_dut_rst_n <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN) ||
                           (w_state_nxt == S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (ld_clr)       r_loaded <= '0;
                    else if (w_ld_we) r_loaded <= r_loaded + LW'(1);
                    if (w_start_ok) begin
                        r_len       <= w_eff_len;
                        r_loop      <= loop;
                        r_skip_cnt  <= skip;
                        r_cap_count <= '0;
                        r_overflow  <= 1'b0;
                        r_cnt       <= '0;
                        r_rd_ptr    <= '0;
                        r_dec       <= '0;
                    end
                end
                S_RESET: begin
                    r_cnt <= w_cnt_end ? '0 : r_cnt + CW'(1);
                    // Pre-read sample 0 so it is on dut_in in RUN cycle 0.
                    if (w_cnt_end) begin
                        r_dut_in <= r_stim_ram[r_rd_ptr];
                        r_rd_ptr <= w_rd_ptr_nxt;
                    end
                end
                S_RUN: begin
                    r_cnt <= w_cnt_end ? '0 : r_cnt + CW'(1);
                    if (w_cnt_end) begin
                        r_dut_in <= '0;
                    end else begin
                        r_dut_in <= r_stim_ram[r_rd_ptr];
                        r_rd_ptr <= w_rd_ptr_nxt;
                    end
                end
                S_DRAIN: begin
                    r_cnt <= w_cnt_end ? '0 : r_cnt + CW'(1);
                end
                default: ;
            endcase

            if (w_capturing) begin
                r_dec <= w_dec_hit ? '0 : r_dec + DW'(1);
                if (w_dec_hit) begin
                    if (r_skip_cnt != 16'd0) r_skip_cnt  <= r_skip_cnt - 16'd1;
                    else if (w_res_we)       r_cap_count <= r_cap_count + CAPW'(1);
                    else                     r_overflow  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ld_we) r_stim_ram[r_loaded[AW_IN-1:0]] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (w_res_we) r_res_ram[r_cap_count[AW_OUT-1:0]] <= dut_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rd_data <= '0;
        else      r_rd_data <= r_res_ram[rd_addr];
    end

    assign dut_rst_n = r_dut_rst_n;
    assign dut_in    = r_dut_in;
    assign rd_data   = r_rd_data;
    assign cap_count = r_cap_count;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_stim_capture_harness.sv
// ---------------------------------------------------------------------------
// tb_stim_capture_harness
//
// Two harness instances share every input: u_a decimates by 1, u_b by 4.
// Small depths keep runs short: DEPTH_IN=16, DEPTH_OUT=32, RST_CYC=5,
// DRAIN_CYC=16. Each DUT model converts its 3-bit dut_in to an IEEE float.
// ---------------------------------------------------------------------------
module tb_stim_capture_harness;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ld_clr;
    logic        ld_valid;
    logic [2:0]  ld_data;
    logic        start;
    logic [4:0]  length;
    logic [15:0] skip;
    logic        loop;
    logic [4:0]  rd_addr;

    logic        ld_ready_a, ld_ready_b;
    logic        dut_rst_n_a, dut_rst_n_b;
    logic [2:0]  dut_in_a, dut_in_b;
    logic [31:0] dut_out_a, dut_out_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic [5:0]  cap_count_a, cap_count_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;
    logic        overflow_a, overflow_b;
    logic [2:0]  dbg_state_a, dbg_state_b;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];
    logic [2:0] got_q[$];

    // Integer 0..7 to single-precision float.
    function automatic logic [31:0] to_float(input logic [2:0] v);
        int          p;
        logic [31:0] m;
        if (v == 3'd0) return 32'd0;
        p = v[2] ? 2 : (v[1] ? 1 : 0);
        m = {29'd0, v} << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    assign dut_out_a = to_float(dut_in_a);
    assign dut_out_b = to_float(dut_in_b);

    stim_capture_harness #(
        .N(3), .DEPTH_IN(16), .DEPTH_OUT(32), .OSR(1), .FLOAT_W(32),
        .RST_CYC(5), .DRAIN_CYC(16)
    ) u_a (
        .clk(clk), .rst(rst), .ld_clr(ld_clr), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_ready(ld_ready_a), .start(start),
        .length(length), .skip(skip), .loop(loop), .dut_rst_n(dut_rst_n_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .cap_count(cap_count_a), .busy(busy_a),
        .done(done_a), .overflow(overflow_a), .dbg_state(dbg_state_a)
    );

    stim_capture_harness #(
        .N(3), .DEPTH_IN(16), .DEPTH_OUT(32), .OSR(4), .FLOAT_W(32),
        .RST_CYC(5), .DRAIN_CYC(16)
    ) u_b (
        .clk(clk), .rst(rst), .ld_clr(ld_clr), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_ready(ld_ready_b), .start(start),
        .length(length), .skip(skip), .loop(loop), .dut_rst_n(dut_rst_n_b),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .cap_count(cap_count_b), .busy(busy_b),
        .done(done_b), .overflow(overflow_b), .dbg_state(dbg_state_b)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        ld_clr = 1'b1;
        tick();
        ld_clr = 1'b0;
    endtask

    // Words are i%8; acc counts cycles where the handshake completed.
    task automatic load_words(input int n, output int acc);
        acc = 0;
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = 3'(i % 8);
            if (ld_ready_a) acc++;
            tick();
        end
        ld_valid = 1'b0;
    endtask

    // Starts a run and observes it until a few cycles after done.
    task automatic do_run(input logic [4:0] len, input logic [15:0] sk, input logic lp,
                          output int rst_lo, output int dones, output int dones_b,
                          output int bad_done, output bit timed_out);
        int post;
        got_q.delete();
        rst_lo = 0; dones = 0; dones_b = 0; bad_done = 0; timed_out = 1'b1; post = 0;
        length = len; skip = sk; loop = lp; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (busy_a && !dut_rst_n_a) rst_lo++;
            if (busy_a && dut_rst_n_a)  got_q.push_back(dut_in_a);
            if (done_b) dones_b++;
            if (done_a) begin
                dones++;
                timed_out = 1'b0;
                if (busy_a || !dut_rst_n_a) bad_done++;
            end
            if (!timed_out) post++;
            if (post > 4) break;
            tick();
        end
    endtask

    task automatic read_res(input int addr, output logic [31:0] a, output logic [31:0] b);
        rd_addr = 5'(addr);
        tick();
        a = rd_data_a;
        b = rd_data_b;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; ld_clr = 1'b0; ld_valid = 1'b0; ld_data = '0; start = 1'b0;
        length = '0; skip = '0; loop = 1'b0; rd_addr = '0;
        repeat (3) tick();
        checks++;
        if (ld_ready_a !== 1'b0) begin
            errors++; $display("FAIL reset_ld_ready got %0b exp 0", ld_ready_a);
        end
        checks++;
        if ({busy_a, done_a, dut_rst_n_a, overflow_a, dut_in_a, cap_count_a, rd_data_a} !== 45'd0) begin
            errors++; $display("FAIL reset_outputs_a busy=%0b done=%0b rstn=%0b ovf=%0b in=%0d cap=%0d rd=%0h exp all 0",
                               busy_a, done_a, dut_rst_n_a, overflow_a, dut_in_a, cap_count_a, rd_data_a);
        end
        checks++;
        if ({busy_b, done_b, dut_rst_n_b, overflow_b, cap_count_b} !== 10'd0) begin
            errors++; $display("FAIL reset_outputs_b busy=%0b done=%0b rstn=%0b ovf=%0b cap=%0d exp all 0",
                               busy_b, done_b, dut_rst_n_b, overflow_b, cap_count_b);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (ld_ready_a !== 1'b1 || dbg_state_a !== 3'd0 || dut_rst_n_a !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset ready=%0b state=%0d rstn=%0b exp 1 0 0",
                               ld_ready_a, dbg_state_a, dut_rst_n_a);
        end
    endtask

    task automatic test_load_full();
        int acc;
        load_words(19, acc);
        checks++;
        if (acc != 16) begin
            errors++; $display("FAIL load_full_accepts got %0d exp 16", acc);
        end
        checks++;
        if (ld_ready_a !== 1'b0) begin
            errors++; $display("FAIL load_full_ready got %0b exp 0", ld_ready_a);
        end
        // ld_clr wins over a write in the same cycle: nothing stays loaded.
        ld_valid = 1'b1; ld_data = 3'd5;
        pulse_clr();
        ld_valid = 1'b0;
        checks++;
        if (ld_ready_a !== 1'b1) begin
            errors++; $display("FAIL clr_ready got %0b exp 1", ld_ready_a);
        end
        length = 5'd16; loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        checks++;
        if (busy_a !== 1'b0) begin
            errors++; $display("FAIL start_empty_noloop busy got %0b exp 0", busy_a);
        end
        length = 5'd5; loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        checks++;
        if (busy_a !== 1'b0) begin
            errors++; $display("FAIL start_empty_loop busy got %0b exp 0", busy_a);
        end
    endtask

    task automatic test_basic();
        int acc, rlo, dn, dnb, bad;
        bit to;
        logic [31:0] a, b;
        pulse_clr();
        load_words(8, acc);
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(3'(k));
        do_run(5'd8, 16'd0, 1'b0, rlo, dn, dnb, bad, to);
        checks++;
        if (to || dn != 1 || dnb != 1 || bad != 0) begin
            errors++; $display("FAIL basic_done timeout=%0b dones=%0d/%0d bad=%0d exp 0 1/1 0", to, dn, dnb, bad);
        end
        checks++;
        if (rlo != 5) begin
            errors++; $display("FAIL basic_rst_cycles got %0d exp 5", rlo);
        end
        checks++;
        if (got_q.size() != 24) begin
            errors++; $display("FAIL basic_stream_len got %0d exp 24", got_q.size());
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL basic_dut_in[%0d] got %0d exp %0d", k, got_q[k], exp_q[k]);
            end
        end
        checks++;
        if (got_q[8] !== 3'd0) begin
            errors++; $display("FAIL basic_drain_in got %0d exp 0", got_q[8]);
        end
        checks++;
        if (cap_count_a !== 6'd24 || cap_count_b !== 6'd6 || overflow_a !== 1'b0 || overflow_b !== 1'b0) begin
            errors++; $display("FAIL basic_cap a=%0d b=%0d ovf=%0b%0b exp 24 6 00",
                               cap_count_a, cap_count_b, overflow_a, overflow_b);
        end
        for (int k = 0; k < 8; k++) begin
            read_res(k, a, b);
            checks++;
            if (a !== to_float(3'(k))) begin
                errors++; $display("FAIL basic_rd_a[%0d] got %0h exp %0h", k, a, to_float(3'(k)));
            end
        end
        read_res(8, a, b);
        checks++;
        if (a !== 32'd0) begin
            errors++; $display("FAIL basic_rd_a[8] got %0h exp 0", a);
        end
        read_res(0, a, b);
        checks++;
        if (b !== to_float(3'd3)) begin
            errors++; $display("FAIL basic_rd_b[0] got %0h exp %0h", b, to_float(3'd3));
        end
        read_res(1, a, b);
        checks++;
        if (b !== to_float(3'd7)) begin
            errors++; $display("FAIL basic_rd_b[1] got %0h exp %0h", b, to_float(3'd7));
        end
    endtask

    task automatic test_skip();
        int rlo, dn, dnb, bad;
        bit to;
        logic [31:0] a, b;
        do_run(5'd8, 16'd2, 1'b0, rlo, dn, dnb, bad, to);
        checks++;
        if (to || dn != 1) begin
            errors++; $display("FAIL skip_done timeout=%0b dones=%0d exp 0 1", to, dn);
        end
        checks++;
        if (cap_count_a !== 6'd22 || cap_count_b !== 6'd4) begin
            errors++; $display("FAIL skip_cap a=%0d b=%0d exp 22 4", cap_count_a, cap_count_b);
        end
        read_res(0, a, b);
        checks++;
        if (a !== to_float(3'd2) || b !== 32'd0) begin
            errors++; $display("FAIL skip_rd[0] a=%0h b=%0h exp %0h 0", a, b, to_float(3'd2));
        end
        read_res(5, a, b);
        checks++;
        if (a !== to_float(3'd7)) begin
            errors++; $display("FAIL skip_rd_a[5] got %0h exp %0h", a, to_float(3'd7));
        end
    endtask

    task automatic test_loop();
        int acc, rlo, dn, dnb, bad;
        bit to;
        logic [31:0] a, b;
        pulse_clr();
        load_words(4, acc);
        exp_q.delete();
        for (int k = 0; k < 10; k++) exp_q.push_back(3'(k % 4));
        do_run(5'd10, 16'd0, 1'b1, rlo, dn, dnb, bad, to);
        checks++;
        if (to || dn != 1 || got_q.size() != 26) begin
            errors++; $display("FAIL loop_run timeout=%0b dones=%0d len=%0d exp 0 1 26", to, dn, got_q.size());
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL loop_dut_in[%0d] got %0d exp %0d", k, got_q[k], exp_q[k]);
            end
        end
        checks++;
        if (cap_count_a !== 6'd26 || cap_count_b !== 6'd6) begin
            errors++; $display("FAIL loop_cap a=%0d b=%0d exp 26 6", cap_count_a, cap_count_b);
        end
        read_res(9, a, b);
        checks++;
        if (a !== to_float(3'd1)) begin
            errors++; $display("FAIL loop_rd_a[9] got %0h exp %0h", a, to_float(3'd1));
        end
        read_res(1, a, b);
        checks++;
        if (b !== to_float(3'd3)) begin
            errors++; $display("FAIL loop_rd_b[1] got %0h exp %0h", b, to_float(3'd3));
        end
        // Without loop the run is clipped to the 4 loaded words.
        do_run(5'd10, 16'd0, 1'b0, rlo, dn, dnb, bad, to);
        checks++;
        if (to || got_q.size() != 20 || cap_count_a !== 6'd20) begin
            errors++; $display("FAIL noloop_clip timeout=%0b len=%0d cap=%0d exp 0 20 20", to, got_q.size(), cap_count_a);
        end
    endtask

    task automatic test_overflow();
        int acc, rlo, dn, dnb, bad;
        bit to;
        logic [31:0] a, b;
        pulse_clr();
        load_words(16, acc);
        // 16 samples + 16 drain cycles fill the 32-entry result RAM exactly.
        do_run(5'd16, 16'd0, 1'b0, rlo, dn, dnb, bad, to);
        checks++;
        if (to || cap_count_a !== 6'd32 || overflow_a !== 1'b0) begin
            errors++; $display("FAIL exact_fill timeout=%0b cap=%0d ovf=%0b exp 0 32 0", to, cap_count_a, overflow_a);
        end
        read_res(15, a, b);
        checks++;
        if (a !== to_float(3'd7)) begin
            errors++; $display("FAIL exact_fill_rd[15] got %0h exp %0h", a, to_float(3'd7));
        end
        do_run(5'd20, 16'd0, 1'b1, rlo, dn, dnb, bad, to);
        checks++;
        if (to || dn != 1) begin
            errors++; $display("FAIL ovf_done timeout=%0b dones=%0d exp 0 1", to, dn);
        end
        checks++;
        if (cap_count_a !== 6'd32 || overflow_a !== 1'b1) begin
            errors++; $display("FAIL ovf_a cap=%0d ovf=%0b exp 32 1", cap_count_a, overflow_a);
        end
        checks++;
        if (cap_count_b !== 6'd9 || overflow_b !== 1'b0) begin
            errors++; $display("FAIL ovf_b cap=%0d ovf=%0b exp 9 0", cap_count_b, overflow_b);
        end
        read_res(16, a, b);
        checks++;
        if (a !== to_float(3'd0)) begin
            errors++; $display("FAIL ovf_rd_a[16] got %0h exp 0", a);
        end
    endtask

    task automatic test_abort();
        int acc, rlo, dn, dnb, bad, seen_done;
        bit to, reached;
        logic [31:0] a, b;
        pulse_clr();
        load_words(8, acc);
        length = 5'd8; skip = '0; loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (dut_rst_n_a) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!reached) begin
            errors++; $display("FAIL abort_reach_run got timeout exp dut_rst_n=1");
        end
        repeat (3) tick();
        #2 rst = 1'b0;
        tick();
        checks++;
        if ({busy_a, done_a, dut_rst_n_a, overflow_a, dut_in_a, cap_count_a, rd_data_a, ld_ready_a} !== 46'd0) begin
            errors++; $display("FAIL abort_outputs busy=%0b done=%0b rstn=%0b ovf=%0b in=%0d cap=%0d rd=%0h rdy=%0b exp all 0",
                               busy_a, done_a, dut_rst_n_a, overflow_a, dut_in_a, cap_count_a, rd_data_a, ld_ready_a);
        end
        seen_done = 0;
        for (int c = 0; c < 4; c++) begin
            if (done_a || done_b) seen_done++;
            tick();
        end
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (done_a || done_b) seen_done++;
            tick();
        end
        checks++;
        if (seen_done != 0) begin
            errors++; $display("FAIL abort_no_done got %0d exp 0", seen_done);
        end
        load_words(8, acc);
        do_run(5'd8, 16'd0, 1'b0, rlo, dn, dnb, bad, to);
        checks++;
        if (to || dn != 1 || rlo != 5 || cap_count_a !== 6'd24 || overflow_a !== 1'b0) begin
            errors++; $display("FAIL abort_rerun timeout=%0b dones=%0d rstlo=%0d cap=%0d ovf=%0b exp 0 1 5 24 0",
                               to, dn, rlo, cap_count_a, overflow_a);
        end
        read_res(3, a, b);
        checks++;
        if (a !== to_float(3'd3)) begin
            errors++; $display("FAIL abort_rerun_rd[3] got %0h exp %0h", a, to_float(3'd3));
        end
    endtask

    initial begin
        test_reset();
        test_load_full();
        test_basic();
        test_skip();
        test_loop();
        test_overflow();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stim_capture_harness.md
Name: stim_capture_harness

Overview:
- Synthesizable, parametrised stimulus/capture harness for the control-bounded filter (Batch_top and its successors).
- Stores N-bit control-signal samples in an internal stimulus RAM and generates the DUT reset sequence.
- Streams one sample per clk into the DUT and captures decimated float results into a result RAM, which the host reads back afterwards.
- Used for on-chip and regression runs; the host only loads data, starts the run, waits for done and reads results.

Parameters:
- N, 3, control-signal channel count (sample width).
- DEPTH_IN, 4096, stimulus RAM entries.
- DEPTH_OUT, 4096, result RAM entries.
- OSR, 1, output decimation: capture one result every OSR cycles.
- FLOAT_W, 32, result word width (1+EXP_W+MANT_W).
- RST_CYC, 5, cycles dut_rst_n is held low before streaming.
- DRAIN_CYC, 256, cycles of capture after the last sample (covers DUT latency; ≥ batch depth).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- ld_clr  in  1  pulse: clear stimulus write pointer and loaded count.
- ld_valid  in  1  stimulus word valid.
- ld_data  in  N  stimulus word.
- ld_ready  out  1  harness accepts stimulus (IDLE and not full).
- start  in  1  pulse: begin run.
- length  in  clog2(DEPTH_IN+1)  samples to stream.
- skip  in  16  decimated outputs to discard before capture.
- loop  in  1  1: wrap stimulus pointer until length is reached.
- dut_rst_n  out  1  DUT reset, active low.
- dut_in  out  N  sample to DUT.
- dut_out  in  FLOAT_W  DUT result.
- rd_addr  in  clog2(DEPTH_OUT)  result readback address.
- rd_data  out  FLOAT_W  result word, 1-cycle read latency.
- cap_count  out  clog2(DEPTH_OUT+1)  results captured in the last run.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run end.
- overflow  out  1  sticky: decimated results exceeded DEPTH_OUT.

Behaviour:
- Reset (rst=0): state=IDLE. dut_rst_n=0, dut_in=0, busy=0, done=0, overflow=0, cap_count=0, rd_data=0, ld_ready=0 during reset. Write pointer and loaded count are 0. RAM contents are undefined.
- IDLE:
  - ld_ready=1 while loaded<DEPTH_IN.
  - A handshake (ld_valid&&ld_ready) writes ld_data at wr_ptr; wr_ptr and loaded each increment by 1.
  - ld_valid while full is dropped with no pointer change.
  - ld_clr zeroes the pointers and takes priority over a same-cycle write.
  - dut_rst_n stays low.
- Start:
  - start in IDLE with effective length L>0 → RESET. busy=1, overflow cleared, cap_count cleared.
  - L = min(length, loaded) when loop=0; L = length when loop=1 and loaded>0.
  - start with L=0, or start when not in IDLE, is ignored. If loaded=0, L=0 and start is ignored.
- RESET:
  - dut_rst_n=0 for exactly RST_CYC cycles.
  - Stimulus address 0 is pre-read so sample 0 is valid on dut_in in the first RUN cycle.
  - Then dut_rst_n=1 → RUN.
- RUN:
  - dut_in = sample k in RUN cycle k, k=0..L-1.
  - Address advances by 1 per cycle. With loop=1 the address wraps from loaded-1 to 0.
  - After cycle L-1 → DRAIN, with dut_in forced to 0.
- DRAIN: lasts DRAIN_CYC cycles, then → DONE.
- Capture (RUN and DRAIN):
  - Decimation counter phase 0 in RUN cycle 0; results are taken on phase OSR-1 (OSR=1: every cycle).
  - dut_out is sampled at the clk edge ending that cycle.
  - The first `skip` decimated results are discarded. Later results are written to the result RAM at cap_count, which then increments.
  - At cap_count=DEPTH_OUT further results are dropped and overflow=1 (sticky until next start).
- DONE: done=1 for one cycle; busy=0 in the same cycle; dut_rst_n stays 1 → IDLE. In IDLE after a run, dut_rst_n returns to 0.
- Readback: rd_data=result_ram[rd_addr] one cycle after rd_addr. Reads are allowed at any time; during a run the data read back is undefined.
- Async reset mid-run aborts immediately to reset values. No done pulse.
- Counter widths: clog2 of depth+1; skip counter 16 bits; no counter wraps except the loop address.

Test Plan:
- Load 8 words 0..7 (N=3), start length=8, skip=0, OSR=1, DUT model out=in as float → dut_rst_n low 5 cycles; dut_in 0..7 on consecutive cycles; cap_count=8+DRAIN_CYC; rd_data[0..7]=0..7.
- Same run with OSR=4, skip=2 → results captured on cycles 3,7,11…; the first two discarded; cap_count=(8+DRAIN_CYC)/4-2.
- Load 4 words, loop=1, length=10 → dut_in sequence 0,1,2,3,0,1,2,3,0,1.
- Load DEPTH_IN+3 words → ld_ready falls after DEPTH_IN accepts, loaded=DEPTH_IN; ld_clr then zeroes loaded, ld_ready=1.
- DEPTH_OUT=16, length=32 → cap_count=16, overflow=1, done pulses once; start with loaded=0 → busy stays 0.
- Assert rst low during RUN → all outputs at reset values next cycle, no done; new load+start completes normally.
